// File: rtl/kernel_bc_write_back_ctrl_if.sv
// kernel_bc_write_back_ctrl_if: start-token FIFO, data FIFO, job parameters and write-port bundle
interface kernel_bc_write_back_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  start_empty_n;
  logic                  start_read;
  logic                  start_dout;
  logic                  data_empty_n;
  logic                  data_read;
  logic [DATA_WIDTH-1:0] data_dout;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [CNT_WIDTH-1:0]  num_items;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  done;
  logic                  idle;
  modport master (
    input  start_empty_n, start_dout, data_empty_n, data_dout, base_addr, num_items, wr_ready,
    output start_read, data_read, wr_valid, wr_addr, wr_data, done, idle
  );
  modport slave (
    output start_empty_n, start_dout, data_empty_n, data_dout, base_addr, num_items, wr_ready,
    input  start_read, data_read, wr_valid, wr_addr, wr_data, done, idle
  );
endinterface

// File: rtl/kernel_bc_write_back_ctrl.sv
// kernel_bc_write_back_ctrl: pops a start token, drains num_items words into sequential writes, pulses done
module kernel_bc_write_back_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input logic clk,
  input logic reset,
  kernel_bc_write_back_ctrl_if.master bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  remaining_q, remaining_d;
  logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
  logic                  wr_valid_q, wr_valid_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  done_q;
  logic                  slot_free;
  logic                  pop_data;
  logic                  unused_start_dout;
  assign unused_start_dout = bus.start_dout;
  assign slot_free     = !wr_valid_q | bus.wr_ready;
  assign pop_data      = (state_q == RUN) & bus.data_empty_n & slot_free & (remaining_q != '0);
  assign bus.data_read  = pop_data;
  assign bus.start_read = (state_q == IDLE) & bus.start_empty_n;
  assign bus.wr_valid   = wr_valid_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.done       = done_q;
  assign bus.idle       = state_q == IDLE;
  // next-state and write-slot update: the output slot refills on a pop and empties on accept
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    next_addr_d = next_addr_q;
    wr_valid_d  = wr_valid_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    case (state_q)
      IDLE: if (bus.start_empty_n) begin
        next_addr_d = bus.base_addr;
        remaining_d = bus.num_items;
        state_d     = bus.num_items != '0 ? RUN : DONE;
      end
      RUN: if (pop_data) begin
        wr_data_d   = bus.data_dout;
        wr_addr_d   = next_addr_q;
        wr_valid_d  = 1'b1;
        next_addr_d = next_addr_q + 1'b1;
        remaining_d = remaining_q - 1'b1;
        state_d     = remaining_q == CNT_WIDTH'(1) ? DRAIN : RUN;
      end else if (bus.wr_ready) begin
        wr_valid_d = 1'b0;
      end
      DRAIN: if (slot_free) begin
        wr_valid_d = 1'b0;
        state_d    = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers; done is registered from the upcoming DONE state so it lines up with it
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      next_addr_q <= '0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      next_addr_q <= next_addr_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      done_q      <= state_d == DONE;
    end
  end
endmodule

// File: tb/tb_kernel_bc_write_back_ctrl.sv
// tb_kernel_bc_write_back_ctrl: job table with FIFO models and a write scoreboard
module tb_kernel_bc_write_back_ctrl;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int CW = 16;
  typedef struct {
    logic [AW-1:0] base;
    logic [CW-1:0] num;
    logic [DW-1:0] seed;
    int            stall_at;
    int            stall_len;
    int            exp_lat;
    bit            with_prev;
  } vec_t;
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  kernel_bc_write_back_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();
  kernel_bc_write_back_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  vec_t          jobs_q[$];
  logic [DW-1:0] fifo_q[$];
  wr_t           sb_q[$];
  vec_t          vecs[6];
  vec_t          cur;
  int  n_checks = 0;
  int  n_fail = 0;
  int  cyc = 0;
  int  pop_cyc = 0;
  int  first_wv = -1;
  int  accepted = 0;
  int  done_cnt = 0;
  bit  busy = 1'b0;
  bit  prev_stall = 1'b0;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_data;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive();
    bus.start_empty_n = !reset && jobs_q.size() != 0;
    bus.base_addr     = jobs_q.size() != 0 ? jobs_q[0].base : '0;
    bus.num_items     = jobs_q.size() != 0 ? jobs_q[0].num : '0;
    bus.start_dout    = 1'($urandom_range(1));
    bus.data_empty_n  = !reset && fifo_q.size() != 0;
    bus.data_dout     = fifo_q.size() != 0 ? fifo_q[0] : '0;
    bus.wr_ready      = !(busy && cur.stall_len > 0 && cyc >= pop_cyc + cur.stall_at &&
                          cyc < pop_cyc + cur.stall_at + cur.stall_len);
  endtask

  task automatic sample();
    wr_t w;
    check("idle", bus.idle, !busy);
    if (prev_stall) check("hold_addr_data", {bus.wr_addr, bus.wr_data}, {prev_addr, prev_data});
    prev_stall = bus.wr_valid & !bus.wr_ready;
    prev_addr  = bus.wr_addr;
    prev_data  = bus.wr_data;
    if (bus.data_read) check("read_while_blocked", bus.wr_valid & !bus.wr_ready, 0);
    if (bus.wr_valid) check("wr_valid_outside_job", busy, 1);
    if (bus.start_read) begin
      check("pop_while_busy", busy, 0);
      check("pop_without_token", jobs_q.size() != 0, 1);
      if (jobs_q.size() != 0) begin
        cur = jobs_q.pop_front();
        for (int i = 0; i < int'(cur.num); i++) sb_q.push_back('{cur.base + AW'(i), cur.seed + DW'(i)});
        busy = 1'b1;
        pop_cyc = cyc;
        first_wv = -1;
        accepted = 0;
      end
    end
    if (bus.data_read) begin
      check("data_read_on_empty", fifo_q.size() != 0, 1);
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
    end
    if (bus.wr_valid && busy && first_wv < 0) begin
      first_wv = cyc;
      check("first_wr_valid_latency", cyc - pop_cyc, 2);
    end
    if (bus.wr_valid && bus.wr_ready) begin
      check("write_expected", sb_q.size() != 0, 1);
      if (sb_q.size() != 0) begin
        w = sb_q.pop_front();
        check("wr_addr", bus.wr_addr, w.addr);
        check("wr_data", bus.wr_data, w.data);
        accepted++;
      end
    end
    if (bus.done) begin
      check("done_in_job", busy, 1);
      check("done_latency", cyc - pop_cyc, cur.exp_lat);
      check("writes_outstanding_at_done", sb_q.size(), 0);
      done_cnt++;
      busy = 1'b0;
    end
  endtask

  task automatic step();
    drive();
    @(negedge clk);
    if (!reset) sample();
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic enqueue(vec_t v);
    jobs_q.push_back(v);
    for (int i = 0; i < int'(v.num); i++) fifo_q.push_back(v.seed + DW'(i));
  endtask

  task automatic run_drain(int njobs, int d0);
    int budget = 0;
    while ((jobs_q.size() != 0 || busy || fifo_q.size() != 0) && budget < 300) begin
      step();
      budget++;
    end
    step();
    check("drained", jobs_q.size() + fifo_q.size() + int'(busy), 0);
    check("done_count", done_cnt - d0, njobs);
  endtask

  initial begin
    int i;
    int n;
    int d0;
    int budget;
    vec_t rj;
    vecs[0] = '{32'h0000_0100, 16'd4, 32'hA0, 0, 0, 6, 1'b0};
    vecs[1] = '{32'h0000_0100, 16'd4, 32'hB0, 3, 3, 9, 1'b0};
    vecs[2] = '{32'h0000_0040, 16'd0, 32'h00, 0, 0, 1, 1'b0};
    vecs[3] = '{32'h0000_0000, 16'd2, 32'hC0, 0, 0, 4, 1'b0};
    vecs[4] = '{32'h0000_0010, 16'd1, 32'hD0, 0, 0, 3, 1'b1};
    vecs[5] = '{32'hFFFF_FFFF, 16'd2, 32'hE0, 0, 0, 4, 1'b0};
    cur = vecs[0];
    reset = 1'b1;
    drive();
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_valid", bus.wr_valid, 0);
    check("rst_wr_addr", bus.wr_addr, 0);
    check("rst_wr_data", bus.wr_data, 0);
    check("rst_done", bus.done, 0);
    check("rst_idle", bus.idle, 1);
    check("rst_data_read", bus.data_read, 0);
    reset = 1'b0;
    step();
    i = 0;
    while (i < 6) begin
      d0 = done_cnt;
      n = 1;
      enqueue(vecs[i]);
      while (i + 1 < 6 && vecs[i + 1].with_prev) begin
        i++;
        n++;
        enqueue(vecs[i]);
      end
      run_drain(n, d0);
      i++;
    end
    // reset in the middle of a five-word job
    rj = '{32'h0000_0200, 16'd5, 32'hF0, 0, 0, 7, 1'b0};
    enqueue(rj);
    budget = 0;
    while (accepted < 2 && budget < 50) begin
      step();
      budget++;
    end
    check("two_writes_before_reset", accepted, 2);
    d0 = done_cnt;
    reset = 1'b1;
    jobs_q.delete();
    fifo_q.delete();
    sb_q.delete();
    busy = 1'b0;
    prev_stall = 1'b0;
    step();
    check("mid_rst_wr_valid", bus.wr_valid, 0);
    check("mid_rst_wr_addr", bus.wr_addr, 0);
    check("mid_rst_wr_data", bus.wr_data, 0);
    check("mid_rst_done", bus.done, 0);
    check("mid_rst_idle", bus.idle, 1);
    reset = 1'b0;
    repeat (5) step();
    check("no_done_after_reset", done_cnt - d0, 0);
    enqueue('{32'h0000_0300, 16'd3, 32'h70, 0, 0, 5, 1'b0});
    run_drain(1, d0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
